// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : uart_tx_arbiter
// Brief   : Round-robin, packet-locking arbiter sharing one UART transmitter.
// Revision: 1.0 - initial release
// ============================================================================
module uart_tx_arbiter #(
    parameter int          NUM_REQ      = 4,
    parameter logic [31:0] LOCK_TIMEOUT = 32'd100000,
    localparam int         ID_W         = $clog2(NUM_REQ)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_REQ-1:0]    req_valid,
    input  logic [8*NUM_REQ-1:0]  req_data,
    input  logic [NUM_REQ-1:0]    req_last,
    output logic [NUM_REQ-1:0]    req_ready,
    output logic [7:0]            tx_data,
    output logic                  tx_ok,
    input  logic                  tx_busy,
    output logic [ID_W-1:0]       grant_id,
    output logic                  locked
);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_ISSUE     = 2'd1,
        S_WAIT_BUSY = 2'd2,
        S_WAIT_DONE = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ID_W-1:0]   r_grant;
    logic              r_locked;
    logic [7:0]        r_data;
    logic [31:0]       r_lock_cnt;

    logic              w_timed_out;
    logic              w_lock_eff;
    logic              w_sel_found;
    logic [ID_W-1:0]   w_sel;
    logic [ID_W-1:0]   w_idx;
    logic [7:0]        w_sel_byte;
    logic              w_accept;

    // A lock held by a silent requester expires once the idle count hits the limit.
    assign w_timed_out = (LOCK_TIMEOUT != 32'd0) && (r_lock_cnt >= LOCK_TIMEOUT);
    assign w_lock_eff  = r_locked & ~w_timed_out;

    always_comb begin
        w_sel_found = 1'b0;
        w_sel       = r_grant;
        w_idx       = '0;
        if (w_lock_eff) begin
            w_sel_found = req_valid[r_grant];
        end else begin
            for (int k = 1; k <= NUM_REQ; k++) begin
                w_idx = ID_W'((int'(r_grant) + k) % NUM_REQ);
                if (!w_sel_found && req_valid[w_idx]) begin
                    w_sel_found = 1'b1;
                    w_sel       = w_idx;
                end
            end
        end
    end

    assign w_sel_byte = req_data[{w_sel, 3'b000} +: 8];
    assign w_accept   = (r_state == S_IDLE) && !reset && !tx_busy && w_sel_found;

    assign req_ready = w_accept ? (NUM_REQ'(1) << w_sel) : '0;
    assign tx_ok     = (r_state == S_ISSUE);
    assign tx_data   = r_data;
    assign grant_id  = r_grant;
    assign locked    = w_lock_eff;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:      if (w_accept) w_state_nxt = S_ISSUE;
            S_ISSUE:     w_state_nxt = S_WAIT_BUSY;
            S_WAIT_BUSY: if (tx_busy) w_state_nxt = S_WAIT_DONE;
            S_WAIT_DONE: if (!tx_busy) w_state_nxt = S_IDLE;
            default:     w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_grant    <= ID_W'(NUM_REQ - 1);
            r_locked   <= 1'b0;
            r_data     <= 8'd0;
            r_lock_cnt <= 32'd0;
        end else if (w_accept) begin
            r_grant    <= w_sel;
            r_data     <= w_sel_byte;
            r_locked   <= ~req_last[w_sel];
            r_lock_cnt <= 32'd0;
        end else if (r_state == S_IDLE) begin
            if (!w_lock_eff) begin
                r_locked   <= 1'b0;
                r_lock_cnt <= 32'd0;
            end else if (!req_valid[r_grant] && (r_lock_cnt != 32'hFFFF_FFFF)) begin
                r_lock_cnt <= r_lock_cnt + 32'd1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_uart_tx_arbiter
// Brief   : Directed self-checking bench with a per-cycle behavioural model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_uart_tx_arbiter;

    localparam int          N     = 4;
    localparam int          FRAME = 4;
    localparam logic [31:0] TO    = 32'd20;

    logic              clk = 1'b0;
    logic              reset;
    logic [N-1:0]      req_valid;
    logic [8*N-1:0]    req_data;
    logic [N-1:0]      req_last;
    logic [N-1:0]      req_ready;
    logic [7:0]        tx_data;
    logic              tx_ok;
    logic              tx_busy;
    logic [1:0]        grant_id;
    logic              locked;
    logic              xmit_busy = 1'b0;
    logic              force_busy;

    // second instance: lock never expires
    logic              reset2;
    logic [N-1:0]      valid2;
    logic [8*N-1:0]    data2;
    logic [N-1:0]      last2;
    logic [N-1:0]      ready2;
    logic [7:0]        txd2;
    logic              ok2;
    logic              busy2 = 1'b0;
    logic [1:0]        gid2;
    logic              locked2;

    assign tx_busy = xmit_busy | force_busy;

    initial forever #5 clk = ~clk;

    uart_tx_arbiter #(.NUM_REQ(N), .LOCK_TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
        .req_last(req_last), .req_ready(req_ready), .tx_data(tx_data), .tx_ok(tx_ok),
        .tx_busy(tx_busy), .grant_id(grant_id), .locked(locked)
    );

    uart_tx_arbiter #(.NUM_REQ(N), .LOCK_TIMEOUT(32'd0)) dut_nt (
        .clk(clk), .reset(reset2), .req_valid(valid2), .req_data(data2),
        .req_last(last2), .req_ready(ready2), .tx_data(txd2), .tx_ok(ok2),
        .tx_busy(busy2), .grant_id(gid2), .locked(locked2)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    bit chk_en = 1'b0;
    bit nt_done = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle(input int n);
        repeat (n) step();
    endtask

    // requester byte queues: {last, data}
    logic [8:0]   rbuf [N][32];
    int           rhead [N];
    int           rtail [N];
    logic [N-1:0] en;

    task automatic push(input int i, input logic [7:0] d, input logic last);
        rbuf[i][rtail[i]] = {last, d};
        rtail[i]++;
    endtask

    initial begin
        for (int i = 0; i < N; i++) begin
            rhead[i] = 0;
            rtail[i] = 0;
        end
        forever begin
            @(posedge clk);
            #2;
            for (int i = 0; i < N; i++) begin
                req_valid[i]       = en[i] && (rhead[i] != rtail[i]);
                req_data[8*i +: 8] = rbuf[i][rhead[i]][7:0];
                req_last[i]        = rbuf[i][rhead[i]][8];
            end
        end
    end

    // transmitter: busy for FRAME cycles starting the cycle after ok
    logic [7:0] tx_log [$];
    int         g_log  [$];
    initial begin
        bit seen;
        int bcnt;
        bcnt = 0;
        forever begin
            @(negedge clk);
            seen = tx_ok;
            if (tx_ok) begin
                tx_log.push_back(tx_data);
                g_log.push_back(int'(grant_id));
            end
            @(posedge clk);
            #1;
            if (seen) bcnt = FRAME;
            else if (bcnt > 0) bcnt--;
            xmit_busy = (bcnt != 0);
        end
    end

    initial begin
        bit seen;
        int bcnt;
        bcnt = 0;
        forever begin
            @(negedge clk);
            seen = ok2;
            @(posedge clk);
            #1;
            if (seen) bcnt = 3;
            else if (bcnt > 0) bcnt--;
            busy2 = (bcnt != 0);
        end
    end

    // behavioural model + per-cycle compare
    int            m_grant;
    bit            m_locked;
    logic [7:0]    m_data;
    int unsigned   m_cnt;
    int            m_phase;  // 0 free to accept, 1 strobe due, 2 awaiting busy, 3 awaiting quiet
    bit            eff;
    int            sel;
    logic [N-1:0]  exp_ready;
    int            acc_cyc [N];
    int            last_acc = 0;
    int            prev_acc = 0;
    int            last_ok  = 0;

    initial begin
        m_grant = N - 1; m_locked = 0; m_data = 8'd0; m_cnt = 0; m_phase = 0;
        forever begin
            @(negedge clk);
            if (chk_en) begin
                eff = m_locked && !((TO != 0) && (m_cnt >= TO));
                sel = -1;
                if (m_phase == 0 && !tx_busy && !reset) begin
                    if (eff) begin
                        if (req_valid[m_grant]) sel = m_grant;
                    end else begin
                        for (int k = 1; k <= N; k++)
                            if (sel < 0 && req_valid[(m_grant + k) % N]) sel = (m_grant + k) % N;
                    end
                end
                exp_ready = '0;
                if (sel >= 0) exp_ready[sel] = 1'b1;

                chk("req_ready", req_ready, exp_ready);
                chk("tx_ok", tx_ok, m_phase == 1);
                chk("tx_data", tx_data, m_data);
                chk("grant_id", grant_id, m_grant);
                chk("locked", locked, eff);
                chk("ok_while_busy", tx_ok & tx_busy, 0);

                for (int i = 0; i < N; i++) begin
                    if (req_valid[i] && req_ready[i]) begin
                        rhead[i]++;
                        acc_cyc[i] = cyc;
                        prev_acc   = last_acc;
                        last_acc   = cyc;
                    end
                end
                if (tx_ok) last_ok = cyc;

                if (reset) begin
                    m_grant = N - 1; m_locked = 0; m_data = 8'd0; m_cnt = 0; m_phase = 0;
                end else if (sel >= 0) begin
                    m_grant = sel; m_data = req_data[8*sel +: 8];
                    m_locked = !req_last[sel]; m_cnt = 0; m_phase = 1;
                end else begin
                    case (m_phase)
                        1: m_phase = 2;
                        2: if (tx_busy) m_phase = 3;
                        3: if (!tx_busy) m_phase = 0;
                        default: begin
                            if (!eff) begin
                                m_locked = 0; m_cnt = 0;
                            end else if (!req_valid[m_grant] && m_cnt != 32'hFFFF_FFFF) begin
                                m_cnt++;
                            end
                        end
                    endcase
                end
            end
            cyc++;
        end
    end

    task automatic wait_log(input int n, input string name);
        int k;
        k = 0;
        while (tx_log.size() < n && k < 300) begin
            step();
            k++;
        end
        chk({name, "_log_reached"}, tx_log.size() >= n, 1);
    endtask

    logic [7:0] exp_rr [5] = '{8'h10, 8'h21, 8'h32, 8'h43, 8'h10};
    logic [7:0] exp_lk [4] = '{8'hA0, 8'hA1, 8'hA2, 8'hB0};

    initial begin
        int base;
        reset = 1'b1; req_valid = '0; req_data = '0; req_last = '0;
        en = '1; force_busy = 1'b0;
        step();
        chk_en = 1'b1;
        @(negedge clk);
        chk("rst_tx_ok", tx_ok, 0);
        chk("rst_tx_data", tx_data, 0);
        chk("rst_ready", req_ready, 0);
        chk("rst_locked", locked, 0);
        chk("rst_grant", grant_id, 3);
        step();
        reset = 1'b0;

        // unlocked round robin
        base = tx_log.size();
        push(0, 8'h10, 1); push(0, 8'h10, 1); push(1, 8'h21, 1);
        push(2, 8'h32, 1); push(3, 8'h43, 1);
        wait_log(base + 5, "rr");
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("rr_byte%0d", k), tx_log[base + k], exp_rr[k]);
            chk($sformatf("rr_grant%0d", k), g_log[base + k], k % 4);
        end
        settle(10);

        // packet lock: r2 x3 ahead of waiting r0
        base = tx_log.size();
        push(2, 8'hA0, 0); push(2, 8'hA1, 0); push(2, 8'hA2, 1); push(0, 8'hB0, 1);
        wait_log(base + 4, "lock");
        for (int k = 0; k < 4; k++)
            chk($sformatf("lock_byte%0d", k), tx_log[base + k], exp_lk[k]);
        settle(10);

        // timing: strobe one cycle after acceptance, frame spacing
        base = tx_log.size();
        push(0, 8'h5A, 1); push(0, 8'h5B, 1);
        wait_log(base + 2, "timing");
        chk("ok_latency", last_ok - last_acc, 1);
        chk("frame_gap", last_acc - prev_acc, FRAME + 3);
        settle(10);

        // lock timeout: r1 locks then goes silent, r3 waits
        base = tx_log.size();
        push(1, 8'hC1, 0); push(3, 8'hD3, 1);
        wait_log(base + 2, "timeout");
        chk("to_byte0", tx_log[base], 8'hC1);
        chk("to_byte1", tx_log[base + 1], 8'hD3);
        chk("to_gap", acc_cyc[3] - acc_cyc[1], 27);
        settle(10);

        // busy while idle holds off; r1 withdraws before acceptance
        base = tx_log.size();
        force_busy = 1'b1;
        push(1, 8'hF1, 1);
        settle(4);
        en[1] = 1'b0;
        push(2, 8'hF2, 1);
        settle(3);
        force_busy = 1'b0;
        wait_log(base + 1, "drop");
        settle(10);
        chk("drop_byte", tx_log[base], 8'hF2);
        chk("drop_grant", g_log[base], 2);
        chk("drop_count", tx_log.size(), base + 1);

        // reset during the busy window
        base = tx_log.size();
        push(0, 8'h55, 0);
        wait_log(base + 1, "midrst");
        step();
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("mrst_tx_ok", tx_ok, 0);
        chk("mrst_tx_data", tx_data, 0);
        chk("mrst_ready", req_ready, 0);
        chk("mrst_locked", locked, 0);
        chk("mrst_grant", grant_id, 3);
        step();
        push(0, 8'h66, 1); push(2, 8'h77, 1);
        reset = 1'b0;
        wait_log(base + 3, "postrst");
        chk("postrst_byte0", tx_log[base + 1], 8'h66);
        chk("postrst_grant0", g_log[base + 1], 0);
        chk("postrst_byte1", tx_log[base + 2], 8'h77);
        settle(10);

        // sparse traffic from r3 only
        base = tx_log.size();
        for (int k = 0; k < 3; k++) begin
            push(3, 8'h30 + 8'(k), 1);
            wait_log(base + k + 1, "sparse");
            settle(21);
        end
        for (int k = 0; k < 3; k++)
            chk($sformatf("sparse_byte%0d", k), tx_log[base + k], 8'h30 + 8'(k));

        for (int k = 0; k < 1000 && !nt_done; k++) step();
        chk("nt_finished", nt_done, 1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // LOCK_TIMEOUT=0: r1 locks then goes silent; r3 must never be served
    initial begin
        bit seen1;
        bit seen3;
        reset2 = 1'b1; valid2 = '0; data2 = 32'hD300_A100; last2 = 4'b1000;
        seen1 = 1'b0; seen3 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset2 = 1'b0;
        valid2 = 4'b1010;
        for (int k = 0; k < 20 && !seen1; k++) begin
            @(negedge clk);
            if (ready2[1]) seen1 = 1'b1;
        end
        @(posedge clk);
        #1;
        valid2[1] = 1'b0;
        chk("nt_r1_granted", seen1, 1);
        repeat (150) begin
            @(negedge clk);
            if (ready2[3]) seen3 = 1'b1;
        end
        chk("nt_r3_never", seen3, 0);
        chk("nt_locked", locked2, 1);
        chk("nt_grant", gid2, 1);
        chk("nt_byte", txd2, 8'hA1);
        nt_done = 1'b1;
    end

endmodule
`default_nettype wire
